// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I memory-stage opcodes, funct3 codes, FSM states and pipeline register types
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] load_data;
    logic [31:0] pc;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic        misaligned;
  } mem_wb_t;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [15:0] lane;
  logic        sext;

  assign lane = 16'(rdata >> {addr_lo, 3'b000});
  assign sext = ~funct3[2];

  // Unknown funct3 codes fall through to word behaviour.
  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = |addr_lo;
    case (funct3)
      F3_LB, F3_LBU: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{rs2[7:0]}};
        load_data  = {{24{sext & lane[7]}}, lane[7:0]};
        misaligned = 1'b0;
      end
      F3_LH, F3_LHU: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{rs2[15:0]}};
        load_data  = {{16{sext & lane[15]}}, lane[15:0]};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage: dmem req/gnt/rvalid FSM, op latch and MEM/WB register
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ex_mem_instruction,
  input  logic [XLEN-1:0]   ex_mem_ALUOut,
  input  logic [XLEN-1:0]   ex_mem_rs2_data,
  input  logic [31:0]       ex_mem_pc,
  input  logic [1:0]        ex_mem_mem_to_reg,
  input  logic              ex_mem_regWrite,
  input  logic [4:0]        ex_mem_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_stall,
  output logic              misaligned_exc,
  output logic [31:0]       mem_wb_instruction,
  output logic [XLEN-1:0]   mem_wb_ALUOut,
  output logic [XLEN-1:0]   mem_wb_load_data,
  output logic [31:0]       mem_wb_pc,
  output logic [1:0]        mem_wb_mem_to_reg,
  output logic              mem_wb_regWrite,
  output logic [4:0]        mem_wb_rd
);

  mem_state_e state, state_nxt;
  ex_mem_t    ex_in, op_q, cur;
  mem_wb_t    wb_q, wb_nxt;

  logic        idle, is_load, is_store, is_mem, misaligned, start;
  logic        done_store, done_load;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  assign ex_in = '{instr: ex_mem_instruction, alu: ex_mem_ALUOut, rs2: ex_mem_rs2_data,
                   pc: ex_mem_pc, mem_to_reg: ex_mem_mem_to_reg,
                   reg_write: ex_mem_regWrite, rd: ex_mem_rd};

  // Once an op has been issued everything is driven from the latch, not the EX/MEM inputs.
  assign idle     = (state == IDLE);
  assign cur      = idle ? ex_in : op_q;
  assign is_load  = (cur.instr[6:0] == OPC_LOAD);
  assign is_store = (cur.instr[6:0] == OPC_STORE);
  assign is_mem   = is_load | is_store;

  load_store_align u_align (
    .funct3    (cur.instr[14:12]),
    .addr_lo   (cur.alu[1:0]),
    .rs2       (cur.rs2),
    .rdata     (dmem_rdata),
    .be        (be),
    .wdata     (wdata),
    .load_data (load_data),
    .misaligned(misaligned)
  );

  assign start      = rst_n & idle & is_mem & ~misaligned;
  assign dmem_req   = start | (state == REQ);
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = dmem_req ? {cur.alu[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be : 4'b0000;
  assign dmem_wdata = dmem_req ? wdata : '0;

  assign done_store = dmem_req & is_store & dmem_gnt;
  assign done_load  = (state == RESP) & dmem_rvalid;
  assign mem_stall  = (dmem_req & ~done_store) | ((state == RESP) & ~dmem_rvalid);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = !dmem_gnt ? REQ : (is_load ? RESP : IDLE);
      REQ:     if (dmem_gnt) state_nxt = is_load ? RESP : IDLE;
      RESP:    if (dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion and non-mem ops load MEM/WB; a pending op leaves a bubble behind it.
  always_comb begin
    wb_nxt = '0;
    if (done_store || done_load || (idle && !is_mem)) begin
      wb_nxt.instr      = cur.instr;
      wb_nxt.alu        = cur.alu;
      wb_nxt.load_data  = done_load ? load_data : 32'd0;
      wb_nxt.pc         = cur.pc;
      wb_nxt.mem_to_reg = cur.mem_to_reg;
      wb_nxt.reg_write  = cur.reg_write;
      wb_nxt.rd         = cur.rd;
    end else if (idle && misaligned) begin
      wb_nxt.instr      = cur.instr;
      wb_nxt.alu        = cur.alu;
      wb_nxt.pc         = cur.pc;
      wb_nxt.mem_to_reg = cur.mem_to_reg;
      wb_nxt.rd         = cur.rd;
      wb_nxt.misaligned = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      wb_q  <= wb_nxt;
      if (start) op_q <= ex_in;
    end
  end

  assign misaligned_exc     = wb_q.misaligned;
  assign mem_wb_instruction = wb_q.instr;
  assign mem_wb_ALUOut      = wb_q.alu;
  assign mem_wb_load_data   = wb_q.load_data;
  assign mem_wb_pc          = wb_q.pc;
  assign mem_wb_mem_to_reg  = wb_q.mem_to_reg;
  assign mem_wb_regWrite    = wb_q.reg_write;
  assign mem_wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ex_mem_instruction, ex_mem_ALUOut, ex_mem_rs2_data, ex_mem_pc;
  logic [1:0]  ex_mem_mem_to_reg;
  logic        ex_mem_regWrite;
  logic [4:0]  ex_mem_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misaligned_exc;
  logic [31:0] mem_wb_instruction, mem_wb_ALUOut, mem_wb_load_data, mem_wb_pc;
  logic [1:0]  mem_wb_mem_to_reg;
  logic        mem_wb_regWrite;
  logic [4:0]  mem_wb_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] sw_i, lb_i, lhu_i, sb_i, lw_i, lh_i, add_i;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_instruction(ex_mem_instruction), .ex_mem_ALUOut(ex_mem_ALUOut),
    .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_pc(ex_mem_pc),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_regWrite(ex_mem_regWrite),
    .ex_mem_rd(ex_mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misaligned_exc(misaligned_exc),
    .mem_wb_instruction(mem_wb_instruction), .mem_wb_ALUOut(mem_wb_ALUOut),
    .mem_wb_load_data(mem_wb_load_data), .mem_wb_pc(mem_wb_pc),
    .mem_wb_mem_to_reg(mem_wb_mem_to_reg), .mem_wb_regWrite(mem_wb_regWrite),
    .mem_wb_rd(mem_wb_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic set_op(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [1:0] m2r, input logic rw,
                        input logic [4:0] rd);
    ex_mem_instruction = instr;
    ex_mem_ALUOut      = alu;
    ex_mem_rs2_data    = rs2;
    ex_mem_pc          = pc;
    ex_mem_mem_to_reg  = m2r;
    ex_mem_regWrite    = rw;
    ex_mem_rd          = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_bubble_instr"}, mem_wb_instruction, 32'd0);
    chk({tag, "_bubble_rw"}, {31'd0, mem_wb_regWrite}, 32'd0);
  endtask

  initial begin
    sw_i  = mk(F3_SW, OPC_STORE);
    lb_i  = mk(F3_LB, OPC_LOAD);
    lhu_i = mk(F3_LHU, OPC_LOAD);
    sb_i  = mk(F3_SB, OPC_STORE);
    lw_i  = mk(F3_LW, OPC_LOAD);
    lh_i  = mk(F3_LH, OPC_LOAD);
    add_i = 32'h0020_81B3;

    rst_n = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_exc", {31'd0, misaligned_exc}, 32'd0);
    chk("rst_wb_instr", mem_wb_instruction, 32'd0);
    chk("rst_wb_pc", mem_wb_pc, 32'd0);
    rst_n = 1'b1;

    // SW 0xDEADBEEF @0x100 granted immediately
    set_op(sw_i, 32'h100, 32'hDEAD_BEEF, 32'h40, 2'd0, 1'b0, 5'd0);
    dmem_gnt = 1'b1;
    #1;
    chk("sw_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("sw_wb_instr", mem_wb_instruction, sw_i);
    chk("sw_wb_alu", mem_wb_ALUOut, 32'h100);
    chk("sw_wb_pc", mem_wb_pc, 32'h40);

    // LB @0x101, rvalid one cycle after gnt
    set_op(lb_i, 32'h101, 32'd0, 32'h44, 2'd1, 1'b1, 5'd5);
    #1;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", {28'd0, dmem_be}, 32'h2);
    chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
    tick();
    chk_bubble("lb");
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8000;
    #1;
    chk("lb_req_resp", {31'd0, dmem_req}, 32'd0);
    chk("lb_stall2", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("lb_data", mem_wb_load_data, 32'hFFFF_FF80);
    chk("lb_wb_rw", {31'd0, mem_wb_regWrite}, 32'd1);
    chk("lb_wb_rd", {27'd0, mem_wb_rd}, 32'd5);
    chk("lb_wb_m2r", {30'd0, mem_wb_mem_to_reg}, 32'd1);
    chk("lb_wb_alu", mem_wb_ALUOut, 32'h101);

    // LHU @0x102 back to back
    set_op(lhu_i, 32'h102, 32'd0, 32'h48, 2'd1, 1'b1, 5'd6);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    #1;
    chk("lhu_be", {28'd0, dmem_be}, 32'hC);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    tick();
    chk("lhu_data", mem_wb_load_data, 32'h0000_BEEF);
    chk("lhu_wb_rd", {27'd0, mem_wb_rd}, 32'd6);

    // SB 0xA5 @0x103
    set_op(sb_i, 32'h103, 32'h1234_56A5, 32'h4C, 2'd0, 1'b0, 5'd0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    #1;
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_stall", {31'd0, mem_stall}, 32'd0);
    tick();

    // LW @0x102 misaligned
    set_op(lw_i, 32'h102, 32'd0, 32'h50, 2'd1, 1'b1, 5'd9);
    dmem_gnt = 1'b0;
    #1;
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("lw_mis_exc", {31'd0, misaligned_exc}, 32'd1);
    chk("lw_mis_rw", {31'd0, mem_wb_regWrite}, 32'd0);
    chk("lw_mis_instr", mem_wb_instruction, lw_i);

    // LH @0x101 misaligned
    set_op(lh_i, 32'h101, 32'd0, 32'h54, 2'd1, 1'b1, 5'd9);
    #1;
    chk("lh_mis_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("lh_mis_exc", {31'd0, misaligned_exc}, 32'd1);

    // ADD passes through; exception lasts one cycle only
    set_op(add_i, 32'h77, 32'h0, 32'h58, 2'd0, 1'b1, 5'd3);
    tick();
    chk("add_exc_clr", {31'd0, misaligned_exc}, 32'd0);
    chk("add_wb_instr", mem_wb_instruction, add_i);
    chk("add_wb_rw", {31'd0, mem_wb_regWrite}, 32'd1);

    // SW @0x200 with gnt delayed 3 cycles; EX/MEM inputs garbled after issue
    set_op(sw_i, 32'h200, 32'h1234_5678, 32'h5C, 2'd0, 1'b0, 5'd0);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt = 1'b1;
      #1;
      chk($sformatf("sw5_req%0d", i), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("sw5_addr%0d", i), dmem_addr, 32'h200);
      chk($sformatf("sw5_be%0d", i), {28'd0, dmem_be}, 32'hF);
      chk($sformatf("sw5_wdata%0d", i), dmem_wdata, 32'h1234_5678);
      chk($sformatf("sw5_stall%0d", i), {31'd0, mem_stall}, (i == 3) ? 32'd0 : 32'd1);
      tick();
      if (i < 3) chk_bubble($sformatf("sw5_%0d", i));
      ex_mem_ALUOut = 32'hFFFF_FFF0; ex_mem_rs2_data = 32'h0BAD_0BAD;
    end
    chk("sw5_wb_instr", mem_wb_instruction, sw_i);
    chk("sw5_wb_alu", mem_wb_ALUOut, 32'h200);
    dmem_gnt = 1'b0;

    // LW in RESP interrupted by reset; stray rvalid afterwards
    set_op(lw_i, 32'h300, 32'd0, 32'h60, 2'd1, 1'b1, 5'd4);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("rsp_stall_pre", {31'd0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsp_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rsp_rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rsp_rst_addr", dmem_addr, 32'd0);
    chk("rsp_rst_wb", mem_wb_instruction, 32'd0);
    set_op(32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    tick(); tick();
    rst_n = 1'b1;
    set_op(add_i, 32'h55, 32'h0, 32'h64, 2'd0, 1'b1, 5'd7);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_stall", {31'd0, mem_stall}, 32'd0);
    chk("stray_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("stray_wb_instr", mem_wb_instruction, add_i);
    chk("stray_wb_alu", mem_wb_ALUOut, 32'h55);
    chk("stray_wb_ld", mem_wb_load_data, 32'd0);
    chk("stray_wb_rd", {27'd0, mem_wb_rd}, 32'd7);
    dmem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
